// File: rtl/pipelined_rca.sv
// Pipelined carry-chain adder/subtractor: the WIDTH-bit chain is split into STAGES
// chunks with a register after each, behind a global valid/ready stall.
module pipelined_rca #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int CHUNK  = WIDTH / STAGES;
  localparam int CHUNK1 = CHUNK + 1;
  localparam int LAST   = STAGES - 1;

  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] carry_q;
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic              ovf_q;

  logic [STAGES-1:0] v_src;
  logic [STAGES-1:0] c_src;
  logic [WIDTH-1:0]  a_src [STAGES];
  logic [WIDTH-1:0]  b_src [STAGES];
  logic [WIDTH-1:0]  s_src [STAGES];
  logic [CHUNK:0]    chunk [STAGES];
  logic [WIDTH-1:0]  sum_d [STAGES];
  logic [STAGES-1:0] carry_d;
  logic              ovf_d;
  logic              advance;

  assign out_valid = valid_q[LAST];
  assign Sum       = sum_q[LAST];
  assign Cout      = carry_q[LAST];
  assign Ovf       = ovf_q;
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance && rst_n;

  // Stage k consumes chunk k of the operands carried down from stage k-1 (skewed pipeline).
  always_comb begin
    v_src    = '0;
    c_src    = '0;
    a_src[0] = A;
    b_src[0] = Sub ? ~B : B;
    c_src[0] = Sub ? ~Cin : Cin;
    s_src[0] = '0;
    v_src[0] = in_valid;
    for (int unsigned k = 1; k < STAGES; k++) begin
      a_src[k] = a_q[k-1];
      b_src[k] = b_q[k-1];
      s_src[k] = sum_q[k-1];
      c_src[k] = carry_q[k-1];
      v_src[k] = valid_q[k-1];
    end
    carry_d = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      chunk[k] = {1'b0, a_src[k][k*CHUNK +: CHUNK]}
               + {1'b0, b_src[k][k*CHUNK +: CHUNK]}
               + CHUNK1'(c_src[k]);
      sum_d[k] = s_src[k];
      sum_d[k][k*CHUNK +: CHUNK] = chunk[k][CHUNK-1:0];
      carry_d[k] = chunk[k][CHUNK];
    end
    ovf_d = (a_src[LAST][WIDTH-1] == b_src[LAST][WIDTH-1]) &&
            (sum_d[LAST][WIDTH-1] != a_src[LAST][WIDTH-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      carry_q <= '0;
      ovf_q   <= 1'b0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
      end
    end else if (advance) begin
      valid_q <= v_src;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      for (int unsigned k = 0; k < STAGES; k++) begin
        a_q[k]   <= a_src[k];
        b_q[k]   <= b_src[k];
        sum_q[k] <= sum_d[k];
      end
    end
  end

endmodule

// File: tb/tb_pipelined_rca.sv
// Bench for pipelined_rca: four parameterisations share one stimulus stream and are
// checked every cycle against an arithmetic reference with a stall-aware delay line.
module tb_pipelined_rca;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        Cin = 1'b0;
  logic        Sub = 1'b0;
  logic [15:0] A = '0;
  logic [15:0] B = '0;

  logic [3:0]  ir, ov, co, of;
  logic [15:0] sm0, sm1, sm2;
  logic [7:0]  sm3;

  int n_cmp = 0;
  int n_err = 0;

  int dep [4] = '{4, 1, 16, 2};
  int wid [4] = '{16, 16, 16, 8};
  logic        mv   [4][16];
  logic [17:0] mres [4][16];

  always #5 clk = ~clk;

  pipelined_rca #(.WIDTH(16), .STAGES(4)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
    .A(A), .B(B), .Cin(Cin), .Sub(Sub), .out_valid(ov[0]), .out_ready(out_ready),
    .Sum(sm0), .Cout(co[0]), .Ovf(of[0]));
  pipelined_rca #(.WIDTH(16), .STAGES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
    .A(A), .B(B), .Cin(Cin), .Sub(Sub), .out_valid(ov[1]), .out_ready(out_ready),
    .Sum(sm1), .Cout(co[1]), .Ovf(of[1]));
  pipelined_rca #(.WIDTH(16), .STAGES(16)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]),
    .A(A), .B(B), .Cin(Cin), .Sub(Sub), .out_valid(ov[2]), .out_ready(out_ready),
    .Sum(sm2), .Cout(co[2]), .Ovf(of[2]));
  pipelined_rca #(.WIDTH(8), .STAGES(2)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[3]),
    .A(A[7:0]), .B(B[7:0]), .Cin(Cin), .Sub(Sub), .out_valid(ov[3]), .out_ready(out_ready),
    .Sum(sm3), .Cout(co[3]), .Ovf(of[3]));

  function automatic logic [15:0] sum_of(int d);
    case (d)
      0:       return sm0;
      1:       return sm1;
      2:       return sm2;
      default: return {8'h00, sm3};
    endcase
  endfunction

  // {carry, overflow, sum} from plain integer arithmetic on the w-bit operands.
  function automatic logic [17:0] ref_op(int w, logic [15:0] a, logic [15:0] b,
                                         logic cin, logic sub);
    int mask, half, ua, ub, ci, sa, sb, u, s;
    logic c;
    mask = (1 << w) - 1;
    half = 1 << (w - 1);
    ua   = int'(a) & mask;
    ub   = int'(b) & mask;
    ci   = int'(cin);
    sa   = (ua >= half) ? ua - 2 * half : ua;
    sb   = (ub >= half) ? ub - 2 * half : ub;
    if (sub) begin
      u = ua - ub - ci;
      c = (u >= 0);
      s = sa - sb - ci;
    end else begin
      u = ua + ub + ci;
      c = (u > mask);
      s = sa + sb + ci;
    end
    return {c, (s >= half) || (s < -half), 16'(u & mask)};
  endfunction

  task automatic chk(string tag, int d, logic [19:0] obs, logic [19:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s dut%0d observed=%h expected=%h", tag, d, obs, exp);
    end
  endtask

  // Reference pipeline: a result enters at the accepting edge and moves one slot per
  // non-stalled edge; the last slot is what the outputs must show.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 4; d++)
        for (int k = 0; k < 16; k++) mv[d][k] <= 1'b0;
    end else begin
      for (int d = 0; d < 4; d++) begin
        if (!mv[d][dep[d]-1] || out_ready) begin
          for (int k = 1; k < 16; k++) begin
            if (k < dep[d]) begin
              mv[d][k]   <= mv[d][k-1];
              mres[d][k] <= mres[d][k-1];
            end
          end
          mv[d][0]   <= in_valid;
          mres[d][0] <= ref_op(wid[d], A, B, Cin, Sub);
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 4; d++) begin
      chk("in_ready", d, 20'(ir[d]), 20'(rst_n && (!mv[d][dep[d]-1] || out_ready)));
      chk("out_valid", d, 20'(ov[d]), 20'(rst_n && mv[d][dep[d]-1]));
      if (!rst_n)
        chk("reset_outputs", d, {2'b00, co[d], of[d], sum_of(d)}, '0);
      else if (mv[d][dep[d]-1])
        chk("result", d, {2'b00, co[d], of[d], sum_of(d)}, {2'b00, mres[d][dep[d]-1]});
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic send(logic [15:0] a, logic [15:0] b, logic cin, logic sub);
    A = a; B = b; Cin = cin; Sub = sub;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic chk_out(string tag, int d, logic [15:0] es, logic ec, logic eo);
    chk(tag, d, {1'b0, ov[d], co[d], of[d], sum_of(d)}, {1'b0, 1'b1, ec, eo, es});
  endtask

  task automatic chk_reset(string tag);
    for (int d = 0; d < 4; d++)
      chk(tag, d, {ir[d], ov[d], co[d], of[d], sum_of(d)}, '0);
  endtask

  // One isolated op: checks the constant result at the exact latency of STAGES=1, 4, 16.
  task automatic directed(logic [15:0] a, logic [15:0] b, logic cin, logic sub,
                          logic [15:0] es, logic ec, logic eo);
    send(a, b, cin, sub);
    chk_out("vec_lat1", 1, es, ec, eo);
    repeat (3) step();
    chk_out("vec_lat4", 0, es, ec, eo);
    step();
    chk("vec_lat4_one_cycle", 0, 20'(ov[0]), 20'd0);
    repeat (11) step();
    chk_out("vec_lat16", 2, es, ec, eo);
    step();
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk_reset("reset_state");
    rst_n = 1'b1;
    idle(2);

    out_ready = 1'b1;
    directed(16'h0003, 16'h0005, 1'b0, 1'b0, 16'h0008, 1'b0, 1'b0);
    directed(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    directed(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    directed(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    directed(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    directed(16'h0005, 16'h0002, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0);

    send(16'h00FF, 16'h0001, 1'b0, 1'b0);
    step();
    chk_out("w8_lat2", 3, 16'h0000, 1'b1, 1'b0);
    idle(16);

    // Back-to-back ops with one input gap and out_ready low for cycles 6..8.
    for (int c = 0; c < 12; c++) begin
      in_valid  = (c != 3) && (c < 9);
      A         = 16'(c);
      B         = 16'(c * 16'h1000);
      Cin       = 1'b0;
      Sub       = 1'b0;
      out_ready = !(c >= 6 && c <= 8);
      step();
    end
    out_ready = 1'b1;
    idle(18);

    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      A   = 16'($urandom);
      B   = 16'($urandom);
      Cin = 1'($urandom);
      Sub = 1'($urandom);
      step();
    end
    rst_n = 1'b0;
    #1;
    chk_reset("mid_stream_reset");
    idle(2);
    rst_n = 1'b1;
    idle(20);

    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      A   = 16'($urandom);
      B   = 16'($urandom);
      Cin = 1'($urandom);
      Sub = 1'($urandom);
      step();
    end
    out_ready = 1'b1;
    idle(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
